rsa_modexp_core: RTL

- Parametrised, handshaked modular-exponentiation engine: RESULT = BASE^KEY mod N.
- Successor to the fixed-width square/multiply top; generic width W.
- Bit-serial interleaved modular multiplier, so there is no wide multiplier or RAM reduction table.
- Optional constant-time mode; explicit start/ready/done/err handshake for integration under a bus or host FSM.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/rsa_modmul.sv | 60 ++++++
 rtl/rsa_modexp_core.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular-exponentiation core.
package rsa_pkg;

  // Core FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RBASE = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    FIN   = 3'd5
  } state_e;

  // Cycles from the accept cycle to the done-high cycle for a well-formed job
  // (modulus >= 2). Error jobs always take 2 cycles.
  function automatic int unsigned latency(input int unsigned w,
                                          input bit const_time,
                                          input logic [63:0] key);
    int unsigned ones;
    ones = 0;
    for (int unsigned k = 0; k < w; k++) begin
      if (key[k]) ones++;
    end
    if (const_time) return 2 + w + 2 * w * w;
    return 2 + w + w * w + w * ones;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one bit of b per
// cycle, MSB first. The go cycle already performs the first step, so a job
// occupies exactly W cycles and valid is high in the last of them, with p
// carrying the finished product. Operands must stay stable for the whole job
// and a must be < n.
module rsa_modmul #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] p
);

  localparam int JW = (W > 1) ? $clog2(W) : 1;

  logic [W+1:0]  acc_q, acc_d;
  logic [JW-1:0] j_q, j_d;
  logic          busy_q, busy_d;

  logic          active;
  logic [W+1:0]  acc_in, sum, red1, red2, n_ext;
  logic [JW-1:0] j_cur;

  // One shift-add step followed by up to two conditional subtractions of n.
  always_comb begin
    active = go | busy_q;
    acc_in = go ? '0 : acc_q;
    j_cur  = go ? JW'(W - 1) : j_q;
    n_ext  = {2'b00, n};
    sum    = {acc_in[W:0], 1'b0} + (b[j_cur] ? {2'b00, a} : '0);
    red1   = (sum  >= n_ext) ? (sum  - n_ext) : sum;
    red2   = (red1 >= n_ext) ? (red1 - n_ext) : red1;
    acc_d  = active ? red2 : acc_q;
    j_d    = active ? (j_cur - 1'b1) : j_q;
    busy_d = active && (j_cur != '0);
    valid  = active && (j_cur == '0);
    p      = red2[W-1:0];
    busy   = busy_q;
  end

  // Accumulator, bit index and busy flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      j_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      j_q    <= j_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply modular exponentiation:
// result = base^key mod modulus, built on one shared bit-serial multiplier.
//
// Handshake: a job is accepted on a rising edge where ready=1 and start=1;
// key/base/modulus are captured on that edge and may change afterwards.
// start while ready=0 is ignored. done pulses for one cycle in FIN, with err
// and result valid from that cycle and held until the next accept.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int W          = 6,
  parameter int CONST_TIME = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] key,
  input  logic [W-1:0] base,
  input  logic [W-1:0] modulus,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic [W-1:0]  key_q, base_q, n_q, r_q, br_q, result_q;
  logic [IW-1:0] i_q;
  logic          err_q;

  logic          mm_go, mm_busy, mm_valid;
  logic [W-1:0]  mm_a, mm_b, mm_p;
  logic          key_bit, take_mul;

  rsa_modmul #(.W(W)) u_modmul (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (mm_go),
    .a       (mm_a),
    .b       (mm_b),
    .n       (n_q),
    .busy    (mm_busy),
    .valid   (mm_valid),
    .p       (mm_p)
  );

  // Operand steering for the shared multiplier; a job starts on the first
  // cycle of each arithmetic state, when the multiplier is idle.
  always_comb begin
    key_bit  = key_q[i_q];
    take_mul = (CONST_TIME != 0) || key_bit;
    mm_a     = '0;
    mm_b     = '0;
    unique case (state_q)
      RBASE:   begin mm_a = W'(1); mm_b = base_q; end
      SQR:     begin mm_a = r_q;   mm_b = r_q;    end
      MUL:     begin mm_a = r_q;   mm_b = br_q;   end
      default: begin mm_a = '0;    mm_b = '0;     end
    endcase
    mm_go = ((state_q == RBASE) || (state_q == SQR) || (state_q == MUL)) && !mm_busy;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = (n_q < W'(2)) ? FIN : RBASE;
      RBASE: if (mm_valid) state_d = SQR;
      SQR:   if (mm_valid) state_d = take_mul ? MUL : ((i_q == '0) ? FIN : SQR);
      MUL:   if (mm_valid) state_d = (i_q == '0) ? FIN : SQR;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready  = (state_q == IDLE);
    busy   = (state_q != IDLE);
    done   = (state_q == FIN);
    err    = err_q;
    result = result_q;
  end

  // Datapath: operand capture, running result, key bit index, final result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q    <= '0;
      base_q   <= '0;
      n_q      <= '0;
      r_q      <= '0;
      br_q     <= '0;
      i_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            key_q  <= key;
            base_q <= base;
            n_q    <= modulus;
            err_q  <= 1'b0;
          end
        end
        LOAD: begin
          r_q <= W'(1);
          i_q <= IW'(W - 1);
          if (n_q < W'(2)) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end
        end
        RBASE: begin
          if (mm_valid) br_q <= mm_p;
        end
        SQR: begin
          if (mm_valid) begin
            r_q <= mm_p;
            if (!take_mul) begin
              if (i_q == '0) result_q <= mm_p;
              else           i_q      <= i_q - 1'b1;
            end
          end
        end
        MUL: begin
          if (mm_valid) begin
            if (key_bit) r_q <= mm_p;
            if (i_q == '0) result_q <= key_bit ? mm_p : r_q;
            else           i_q      <= i_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
